// File: rtl/spike_rate_meter.sv
// Windowed spike-rate meter with a valid/ready result port and sticky drop flag.
// Optional inter-spike interval measurement is enabled by defining ISI_MEASURE_EN.
module spike_rate_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             spike,
    input  logic [CNT_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             drop,
    output logic [CNT_W-1:0] isi_out,
    output logic             isi_valid
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [CNT_W-1:0] idx, len_q, cnt;
    logic [CNT_W-1:0] cur_idx, cur_len, cur_cnt, cnt_next;
    logic             close;

    // The entry cycle (IDLE with ena=1) is window cycle 0, so it behaves like RUN
    // with index 0 and count 0; window cycle 0 always samples win_len live.
    always_comb begin
        state_next = state;
        cur_idx    = '0;
        cur_cnt    = '0;
        cur_len    = win_len;
        cnt_next   = '0;
        close      = 1'b0;
        case (state)
            IDLE:    if (ena)  state_next = RUN;
            RUN:     if (!ena) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state == RUN) begin
            cur_idx = idx;
            cur_cnt = cnt;
        end
        if (cur_idx != '0) cur_len = len_q;
        cnt_next = (spike && cur_cnt != MAX) ? cur_cnt + ONE : cur_cnt;
        close    = ena && (cur_idx == cur_len);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            len_q      <= '0;
            cnt        <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            drop       <= 1'b0;
        end else begin
            if (ena && !close) begin
                idx <= cur_idx + ONE;
                cnt <= cnt_next;
                if (cur_idx == '0) len_q <= win_len;
            end else begin
                idx <= '0;
                cnt <= '0;
            end
            // A new result may replace one being consumed this same edge.
            if (close) begin
                if (!rate_valid || rate_ready) begin
                    rate_out   <= cnt_next;
                    rate_valid <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end
        end
    end

`ifdef ISI_MEASURE_EN
    logic [CNT_W-1:0] isi_cnt;
    logic             seen;

    // isi_cnt is cycles elapsed since the last spike; the interval is one more.
    always_ff @(posedge clk) begin
        if (reset) begin
            isi_cnt   <= '0;
            seen      <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else if (!ena) begin
            isi_cnt   <= '0;
            seen      <= 1'b0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= spike && seen;
            if (spike) begin
                seen    <= 1'b1;
                isi_cnt <= '0;
                if (seen) isi_out <= (isi_cnt == MAX) ? MAX : isi_cnt + ONE;
            end else if (isi_cnt != MAX) begin
                isi_cnt <= isi_cnt + ONE;
            end
        end
    end
`else
    assign isi_out   = '0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed self-checking bench for spike_rate_meter; ISI checks follow ISI_MEASURE_EN.
module tb_spike_rate_meter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       spike = 1'b0;
    logic [7:0] win_len = 8'd0;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic       rate_ready = 1'b0;
    logic       drop;
    logic [7:0] isi_out;
    logic       isi_valid;

    int total = 0;
    int bad   = 0;

    spike_rate_meter #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .spike      (spike),
        .win_len    (win_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .drop       (drop),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] pat;
        logic [31:0] ev, eo;

        // Reset state
        tick; tick;
        chk("rst_rate_out", rate_out, 0);
        chk("rst_rate_valid", rate_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_isi_out", isi_out, 0);
        chk("rst_isi_valid", isi_valid, 0);
        reset = 1'b0;
        tick;

        // Windows of 10 cycles, spike every 2nd cycle: 5 per window
        win_len = 8'd9; rate_ready = 1'b1; ena = 1'b1;
        for (int i = 0; i < 30; i++) begin
            spike = (i % 2 == 0);
            tick;
            chk("a_valid", rate_valid, (i % 10 == 9));
            if (i % 10 == 9) chk("a_rate", rate_out, 5);
        end
        chk("a_drop", drop, 0);
        ena = 1'b0; spike = 1'b0;
        tick;
        chk("a_valid_clr", rate_valid, 0);

        // Back-pressure: hold, drop, then transfer coincident with a close
        win_len = 8'd3; spike = 1'b1; rate_ready = 1'b0; ena = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick;
            chk("b_valid", rate_valid, (i >= 3));
            if (i >= 3) chk("b_rate", rate_out, 4);
            chk("b_drop", drop, (i >= 7));
        end
        rate_ready = 1'b1;
        tick;
        chk("b_coinc_valid", rate_valid, 1);
        chk("b_coinc_rate", rate_out, 4);
        chk("b_coinc_drop", drop, 1);
        rate_ready = 1'b0;
        tick; tick;

        // Reset mid-window with rate_valid=1 and drop=1
        chk("r_pre_valid", rate_valid, 1);
        chk("r_pre_drop", drop, 1);
        reset = 1'b1;
        tick;
        chk("r_rate_out", rate_out, 0);
        chk("r_rate_valid", rate_valid, 0);
        chk("r_drop", drop, 0);
        chk("r_isi_out", isi_out, 0);
        chk("r_isi_valid", isi_valid, 0);
        // A fresh 4-cycle window after reset proves the FSM restarted from IDLE
        reset = 1'b0; rate_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("r_win_valid", rate_valid, (i == 3));
            if (i == 3) chk("r_win_rate", rate_out, 4);
        end
        ena = 1'b0;
        tick;
        chk("r_valid_clr", rate_valid, 0);

        // Saturation at 255, then 1-cycle windows
        win_len = 8'd255; spike = 1'b1; ena = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) win_len = 8'd0;
            tick;
            chk("c_valid", rate_valid, (i == 255));
        end
        chk("c_sat_rate", rate_out, 255);
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            spike = pat[i];
            tick;
            chk("c_w0_valid", rate_valid, 1);
            chk("c_w0_rate", rate_out, {31'd0, pat[i]});
        end
        ena = 1'b0; spike = 1'b0;
        tick;

        // Partial window aborted by ena=0 yields nothing
        win_len = 8'd9; ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spike = (i % 2 == 0);
            tick;
            chk("d_part_valid", rate_valid, 0);
        end
        ena = 1'b0; spike = 1'b1;
        tick;
        chk("d_idle_valid", rate_valid, 0);
        ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            spike = (i < 2);
            tick;
            chk("d_valid", rate_valid, (i == 9));
            if (i == 9) chk("d_rate", rate_out, 2);
        end
        ena = 1'b0; spike = 1'b0;
        tick;

        // Inter-spike intervals: spikes at 10, 17, 18
        reset = 1'b1;
        tick;
        reset = 1'b0; win_len = 8'd255; ena = 1'b1;
        for (int i = 0; i < 21; i++) begin
            spike = (i == 10 || i == 17 || i == 18);
            tick;
`ifdef ISI_MEASURE_EN
            ev = (i == 17 || i == 18) ? 32'd1 : 32'd0;
            eo = (i < 17) ? 32'd0 : (i == 17) ? 32'd7 : 32'd1;
`else
            ev = 32'd0;
            eo = 32'd0;
`endif
            chk("e_isi_valid", isi_valid, ev);
            chk("e_isi_out", isi_out, eo);
        end
        ena = 1'b0; spike = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
